bus_arbiter_n: RTL

Parametrised N-initiator bus arbiter for the serial bus, the next generation of the two-initiator arbiter. It grants the shared bus to one of NUM_INIT initiators or to the split-capable target, using fixed-priority or round-robin selection. It enforces an optional maximum hold time and parks an initiator whose transaction is split until the target's split grant completes. It sits between the initiator request lines and the bus address/data muxes, which it steers through `sel`.

---
 rtl/bus_arbiter_n.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter_n.sv
// bus_arbiter_n: N-initiator serial-bus arbiter with fixed-priority or
// round-robin selection, optional hold-time pre-emption and split parking.
// All outputs come straight from flops, so they are glitch-free.
module bus_arbiter_n #(
  parameter int NUM_INIT = 2,
  parameter int RR_MODE  = 0,
  parameter int MAX_HOLD = 0,
  parameter int SEL_W    = $clog2(NUM_INIT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_INIT-1:0] req,
  input  logic                req_split,
  input  logic                split_i,
  output logic [NUM_INIT-1:0] grant,
  output logic                grant_split,
  output logic [SEL_W-1:0]    sel,
  output logic                split_pending,
  output logic [SEL_W-1:0]    split_owner,
  output logic                split_err
);

  localparam int IDX_W  = (NUM_INIT < 2) ? 1 : $clog2(NUM_INIT);
  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  // Value at which the hold counter stops counting and expiry is possible.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD < 1) ? 0 : MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SPLIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_owner_q, last_owner_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [NUM_INIT-1:0] park_mask_q, park_mask_d;
  logic [NUM_INIT-1:0] preempt_mask_q, preempt_mask_d;
  logic                split_pending_q, split_pending_d;
  logic [SEL_W-1:0]    split_owner_q, split_owner_d;
  logic                split_err_q, split_err_d;
  logic [NUM_INIT-1:0] grant_q, grant_d;
  logic                grant_split_q, grant_split_d;
  logic [SEL_W-1:0]    sel_q, sel_d;

  logic [NUM_INIT-1:0] eligible_s;
  logic [NUM_INIT-1:0] owner_bit_s;
  logic                competitor_s;
  logic                expire_s;
  logic [IDX_W-1:0]    pick_s;

  // Choose the next owner: lowest index in fixed mode, or first eligible
  // index after the previous owner (wrapping) in round-robin mode.
  function automatic logic [IDX_W-1:0] pick_owner(input logic [NUM_INIT-1:0] elig,
                                                  input logic [IDX_W-1:0]    last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_INIT; k++) begin
      if (RR_MODE != 0) begin
        idx = (int'(last) + 1 + k) % NUM_INIT;
      end else begin
        idx = k;
      end
      if (!found && elig[IDX_W'(idx)]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Next-state, mask and registered-output computation.
  always_comb begin
    for (int i = 0; i < NUM_INIT; i++) begin
      owner_bit_s[i] = (owner_q == IDX_W'(i));
    end
    eligible_s   = req & ~park_mask_q & ~preempt_mask_q;
    competitor_s = (|(eligible_s & ~owner_bit_s)) | req_split;
    expire_s     = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && competitor_s;
    pick_s       = pick_owner(eligible_s, last_owner_q);

    state_d         = state_q;
    owner_d         = owner_q;
    last_owner_d    = last_owner_q;
    hold_cnt_d      = hold_cnt_q;
    park_mask_d     = park_mask_q;
    // A pre-empted initiator becomes eligible again once it drops req.
    preempt_mask_d  = preempt_mask_q & req;
    split_pending_d = split_pending_q;
    split_owner_d   = split_owner_q;
    split_err_d     = split_i & ((state_q != ST_GRANT) | split_pending_q);

    case (state_q)
      ST_IDLE: begin
        if (req_split) begin
          state_d = ST_SPLIT;
        end else if (|eligible_s) begin
          state_d      = ST_GRANT;
          owner_d      = pick_s;
          last_owner_d = pick_s;
          hold_cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (split_i && !split_pending_q) begin
          // Park takes precedence over release and pre-emption.
          park_mask_d     = park_mask_q | owner_bit_s;
          split_pending_d = 1'b1;
          split_owner_d   = SEL_W'(owner_q) + SEL_W'(1);
          state_d         = ST_IDLE;
        end else if (!(|(req & owner_bit_s))) begin
          state_d = ST_IDLE;
        end else if (expire_s) begin
          preempt_mask_d = preempt_mask_d | owner_bit_s;
          state_d        = ST_IDLE;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      ST_SPLIT: begin
        if (!req_split) begin
          state_d         = ST_IDLE;
          park_mask_d     = '0;
          split_pending_d = 1'b0;
          split_owner_d   = '0;
        end else begin
          state_d = ST_SPLIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    for (int i = 0; i < NUM_INIT; i++) begin
      grant_d[i] = (state_d == ST_GRANT) && (owner_d == IDX_W'(i));
    end
    grant_split_d = (state_d == ST_SPLIT);
    if (state_d == ST_GRANT) begin
      sel_d = SEL_W'(owner_d) + SEL_W'(1);
    end else begin
      sel_d = '0;
    end
  end

  // State, masks and outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      owner_q         <= '0;
      last_owner_q    <= IDX_W'(NUM_INIT - 1);
      hold_cnt_q      <= '0;
      park_mask_q     <= '0;
      preempt_mask_q  <= '0;
      split_pending_q <= 1'b0;
      split_owner_q   <= '0;
      split_err_q     <= 1'b0;
      grant_q         <= '0;
      grant_split_q   <= 1'b0;
      sel_q           <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_owner_q    <= last_owner_d;
      hold_cnt_q      <= hold_cnt_d;
      park_mask_q     <= park_mask_d;
      preempt_mask_q  <= preempt_mask_d;
      split_pending_q <= split_pending_d;
      split_owner_q   <= split_owner_d;
      split_err_q     <= split_err_d;
      grant_q         <= grant_d;
      grant_split_q   <= grant_split_d;
      sel_q           <= sel_d;
    end
  end

  assign grant         = grant_q;
  assign grant_split   = grant_split_q;
  assign sel           = sel_q;
  assign split_pending = split_pending_q;
  assign split_owner   = split_owner_q;
  assign split_err     = split_err_q;

endmodule
